// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared constants, state type and helper for the AES word
//               packer. Provides AES_BLOCK_W/AES_KEY_W, pack_state_t and
//               cnt_width(), the word-counter width for a given word count.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_KEY_W   = 128;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  // Width of a counter that spans 0..num_words-1 (never less than 1 bit).
  function automatic int cnt_width(input int num_words);
    return (num_words <= 1) ? 1 : $clog2(num_words);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_word_shreg.sv
`default_nettype none
// ============================================================================
// Module      : aes_word_shreg
// Description : WORD_W-in, 128-out MSB-first shift register with word counter
//               and sticky full flag. Earlier words move toward the MSBs as
//               new words enter at the LSBs.
// Ports       : clk, rst_n (async active-low)
//               shift_en  - shift word_in in and advance the counter
//               clr       - restart the counter and drop the full flag
//               word_in   - incoming word
//               value_out - current register contents
//               cnt_out   - words shifted since the last wrap/clear
//               full_out  - set when the counter wraps, cleared by the next
//                           shift or by clr
// Revision    : 1.0 - initial release
// ============================================================================
module aes_word_shreg
  import aes_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     shift_en,
  input  logic                                     clr,
  input  logic [WORD_W-1:0]                        word_in,
  output logic [AES_BLOCK_W-1:0]                   value_out,
  output logic [cnt_width(AES_BLOCK_W/WORD_W)-1:0] cnt_out,
  output logic                                     full_out
);

  localparam int NUM_WORDS = AES_BLOCK_W / WORD_W;
  localparam int CNT_W     = cnt_width(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  logic [AES_BLOCK_W-1:0] value_q, value_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   full_q, full_d;

  always_comb begin
    value_d = value_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    if (shift_en) begin
      value_d = {value_q[AES_BLOCK_W-WORD_W-1:0], word_in};
    end
    if (clr) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (shift_en) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d  = '0;
        full_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        full_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

  assign value_out = value_q;
  assign cnt_out   = cnt_q;
  assign full_out  = full_q;

endmodule
`default_nettype wire

// File: rtl/aes_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : aes_word_packer
// Description : Packs a WORD_W-wide stream of key and plaintext words into
//               128-bit key/data blocks for the AES-128 core and presents each
//               block with a valid/ready handshake. The key is snapshotted
//               per block so a key reload never disturbs a pending block.
// Ports       : clk, rst_n (async active-low)
//               key_wr/key_word    - key word stream, MSB-first
//               key_loaded         - a full key has been written
//               s_valid/s_ready/s_word/s_last - plaintext word stream
//               m_valid/m_ready    - block handshake
//               m_data/m_key       - packed block and its key snapshot
// Options     : AES_PACK_PAD_EN - s_last closes a partial block, with the
//               remaining low-order words zero-filled. When undefined s_last
//               is ignored and only full blocks are emitted.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_word_packer
  import aes_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_wr,
  input  logic [WORD_W-1:0]      key_word,
  output logic                   key_loaded,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WORD_W-1:0]      s_word,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [AES_BLOCK_W-1:0] m_data,
  output logic [AES_KEY_W-1:0]   m_key
);

  localparam int NUM_WORDS = AES_BLOCK_W / WORD_W;
  localparam int CNT_W     = cnt_width(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  pack_state_t            state_q, state_d;
  logic                   m_valid_q, m_valid_d;
  logic [AES_BLOCK_W-1:0] m_data_q, m_data_d;
  logic [AES_KEY_W-1:0]   m_key_q, m_key_d;

  logic [AES_KEY_W-1:0]   key_value;
  logic [CNT_W-1:0]       key_cnt_unused;
  logic                   key_full;
  logic [AES_BLOCK_W-1:0] data_value;
  logic [CNT_W-1:0]       data_cnt;
  logic                   data_full_unused;

  logic                   accept;
  logic                   pad_close;
  logic                   block_done;
  logic [AES_BLOCK_W-1:0] data_shift;
  logic [AES_BLOCK_W-1:0] block_value;

  // Key register: its sticky full flag is exactly key_loaded, since the
  // first write of a reload clears it in the same edge.
  aes_word_shreg #(.WORD_W(WORD_W)) u_key_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (key_wr),
    .clr       (1'b0),
    .word_in   (key_word),
    .value_out (key_value),
    .cnt_out   (key_cnt_unused),
    .full_out  (key_full)
  );

  aes_word_shreg #(.WORD_W(WORD_W)) u_data_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (accept),
    .clr       (pad_close),
    .word_in   (s_word),
    .value_out (data_value),
    .cnt_out   (data_cnt),
    .full_out  (data_full_unused)
  );

  assign key_loaded = key_full;
  assign s_ready    = (state_q == FILL) && key_full;
  assign accept     = s_valid && s_ready;

  // Register contents including the word being accepted this cycle; the
  // block is captured from this so m_data loads on the same edge.
  assign data_shift = {data_value[AES_BLOCK_W-WORD_W-1:0], s_word};

`ifdef AES_PACK_PAD_EN
  logic [7:0] pad_shamt;

  // The accepted words sit in the low (data_cnt+1)*WORD_W bits; lifting them
  // to the top leaves zeros in the unused low-order words. For a full block
  // the shift is zero.
  assign pad_close   = accept && s_last;
  assign pad_shamt   = 8'(WORD_W * (NUM_WORDS - 1 - int'(data_cnt)));
  assign block_value = data_shift << pad_shamt;
`else
  logic s_last_unused;

  assign s_last_unused = s_last;
  assign pad_close     = 1'b0;
  assign block_value   = data_shift;
`endif

  assign block_done = accept && ((data_cnt == LAST_CNT) || pad_close);

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_key_d   = m_key_q;
    case (state_q)
      FILL: begin
        // m_key takes the key register as it stands before any key write
        // registered on this same edge.
        if (block_done) begin
          m_data_d  = block_value;
          m_key_d   = key_value;
          m_valid_d = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = FILL;
        end
      end
      default: begin
        state_d   = FILL;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_key_q   <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_key_q   <= m_key_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_key   = m_key_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_word_packer
// Description : Self-checking bench for aes_word_packer (WORD_W=32). A
//               queue-based block model predicts s_ready, m_valid, key_loaded,
//               m_data and m_key every cycle; directed vectors and sequences
//               add constant expectations for the documented corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_word_packer;

  localparam int W = 32;
  localparam int N = 128 / W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           key_wr;
  logic [W-1:0]   key_word;
  logic           key_loaded;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_word;
  logic           s_last;
  logic           m_valid;
  logic           m_ready;
  logic [127:0]   m_data;
  logic [127:0]   m_key;

  always #5 clk = ~clk;

  aes_word_packer #(.WORD_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_wr     (key_wr),
    .key_word   (key_word),
    .key_loaded (key_loaded),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_word     (s_word),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_key      (m_key)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef bit [W-1:0] wq_t[$];

  wq_t        mk_q;
  wq_t        md_q;
  bit         mdl_key_ok;
  bit         mdl_hold;
  bit [127:0] mdl_keyval;
  bit [127:0] mdl_data;
  bit [127:0] mdl_key;

  // Word i of a block occupies bits [127-W*i -: W]; missing words stay zero.
  function automatic bit [127:0] pack_words(input wq_t q);
    bit [127:0] v = '0;
    for (int i = 0; i < q.size(); i++) v[127 - W*i -: W] = q[i];
    return v;
  endfunction

  task automatic model_reset();
    mk_q.delete();
    md_q.delete();
    mdl_key_ok = 1'b0;
    mdl_hold   = 1'b0;
    mdl_keyval = '0;
    mdl_data   = '0;
    mdl_key    = '0;
  endtask

  // One clock: compare outputs, take the edge, advance the model with the
  // inputs that were present at that edge.
  task automatic tick();
    bit rdy;
    bit close;
    rdy = !mdl_hold && mdl_key_ok;
    chk("s_ready",    s_ready,    rdy);
    chk("m_valid",    m_valid,    mdl_hold);
    chk("key_loaded", key_loaded, mdl_key_ok);
    chk("m_data",     m_data,     mdl_data);
    chk("m_key",      m_key,      mdl_key);
    @(posedge clk);
    if (mdl_hold && m_ready) mdl_hold = 1'b0;
    if (s_valid && rdy) begin
      md_q.push_back(s_word);
      close = (md_q.size() == N);
`ifdef AES_PACK_PAD_EN
      close = close || s_last;
`endif
      if (close) begin
        mdl_data = pack_words(md_q);
        mdl_key  = mdl_keyval;
        mdl_hold = 1'b1;
        md_q.delete();
      end
    end
    if (key_wr) begin
      mdl_key_ok = 1'b0;
      mk_q.push_back(key_word);
      if (mk_q.size() == N) begin
        mdl_keyval = pack_words(mk_q);
        mdl_key_ok = 1'b1;
        mk_q.delete();
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid",    m_valid,    '0);
    chk("rst_s_ready",    s_ready,    '0);
    chk("rst_key_loaded", key_loaded, '0);
    chk("rst_m_data",     m_data,     '0);
    chk("rst_m_key",      m_key,      '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_key(input logic [127:0] k);
    for (int i = 0; i < N; i++) begin
      key_wr   = 1'b1;
      key_word = k[127 - W*i -: W];
      tick();
    end
    key_wr = 1'b0;
  endtask

  task automatic send_words(input logic [127:0] p, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      s_valid = 1'b1;
      s_word  = p[127 - W*i -: W];
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    bit           ready_in_fill;
    int           hold;
    logic [127:0] exp_data;
    logic [127:0] exp_key;
  } vec_t;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KF  = {128{1'b1}};
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  vec_t tbl[3];

  initial begin
    tbl[0] = '{key: K1, pt: P1, ready_in_fill: 1'b1, hold: 0,  exp_data: P1, exp_key: K1};
    tbl[1] = '{key: K1, pt: P1, ready_in_fill: 1'b0, hold: 10, exp_data: P1, exp_key: K1};
    tbl[2] = '{key: KF, pt: P2, ready_in_fill: 1'b0, hold: 3,  exp_data: P2, exp_key: KF};

    rst_n = 1'b0; key_wr = 1'b0; key_word = '0; s_valid = 1'b0; s_word = '0;
    s_last = 1'b0; m_ready = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // ---- table-driven vectors ----
    for (int v = 0; v < 3; v++) begin
      send_key(tbl[v].key);
      chk("vec_key_loaded", key_loaded, 1'b1);
      m_ready = tbl[v].ready_in_fill;
      send_words(tbl[v].pt, 0, N-1);
      m_ready = 1'b0;
      chk("vec_m_valid", m_valid, 1'b1);
      chk("vec_m_data",  m_data,  tbl[v].exp_data);
      chk("vec_m_key",   m_key,   tbl[v].exp_key);
      for (int h = 0; h < tbl[v].hold; h++) begin
        s_valid = 1'b1;
        s_word  = W'($urandom);
        tick();
        chk("hold_s_ready", s_ready, 1'b0);
        chk("hold_m_data",  m_data,  tbl[v].exp_data);
      end
      s_valid = 1'b0;
      handshake();
      chk("vec_after_hs", m_valid, 1'b0);
    end

    // ---- key rewritten while a block is held ----
    send_key(K1);
    send_words(P1, 0, N-1);
    send_key(KF);
    chk("hold_key_kept", m_key, K1);
    handshake();
    send_words(P2, 0, N-1);
    chk("next_blk_key", m_key, KF);
    handshake();

    // ---- asynchronous reset mid-block ----
    send_words(P1, 0, 1);
    do_reset();
    s_valid = 1'b1;
    s_word  = 32'hdeadbeef;
    tick();
    tick();
    chk("post_rst_s_ready", s_ready, 1'b0);
    s_valid = 1'b0;
    send_key(K1);
    send_words(P2, 0, N-1);
    chk("post_rst_blk", m_data, P2);
    handshake();

    // ---- key reload in the middle of a fill ----
    send_words(P1, 0, 1);
    key_wr   = 1'b1;
    key_word = KF[127 -: W];
    tick();
    chk("reload_s_ready", s_ready, 1'b0);
    for (int i = 1; i < N; i++) begin
      key_word = KF[127 - W*i -: W];
      tick();
    end
    key_wr = 1'b0;
    send_words(P1, 2, N-1);
    chk("reload_blk_data", m_data, P1);
    chk("reload_blk_key",  m_key,  KF);
    handshake();

    // ---- key write coinciding with the completing data word ----
    send_key(K1);
    send_words(P2, 0, N-2);
    key_wr   = 1'b1;
    key_word = KF[127 -: W];
    s_valid  = 1'b1;
    s_word   = P2[W-1:0];
    tick();
    s_valid = 1'b0;
    chk("coinc_m_key",   m_key,      K1);
    chk("coinc_m_data",  m_data,     P2);
    chk("coinc_loaded",  key_loaded, 1'b0);
    for (int i = 1; i < N; i++) begin
      key_word = KF[127 - W*i -: W];
      tick();
    end
    key_wr = 1'b0;
    handshake();

    // ---- s_last on the second word ----
    s_valid = 1'b1;
    s_word  = 32'h11111111;
    tick();
    s_word  = 32'h22222222;
    s_last  = 1'b1;
    tick();
    s_last  = 1'b0;
    s_valid = 1'b0;
`ifdef AES_PACK_PAD_EN
    chk("pad_m_valid", m_valid, 1'b1);
    chk("pad_m_data",  m_data,  128'h11111111222222220000000000000000);
`else
    chk("nopad_m_valid", m_valid, 1'b0);
    s_valid = 1'b1;
    s_word  = 32'h33333333;
    tick();
    s_word  = 32'h44444444;
    tick();
    s_valid = 1'b0;
    chk("nopad_m_data", m_data, 128'h11111111222222223333333344444444);
`endif
    handshake();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
      key_wr   = ($urandom_range(0, 7) == 0);
      key_word = W'($urandom);
      s_valid  = $urandom_range(0, 1) == 1;
      s_word   = W'($urandom);
      s_last   = ($urandom_range(0, 5) == 0);
      m_ready  = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_word_packer.md
Name: aes_word_packer

Overview:
- Upstream feeder for the combinational AES-128 encryption core.
- Packs a narrow word stream of plaintext and key words into full 128-bit data and key blocks.
- Presents each completed block through a valid/ready handshake, holding it stable until the core-side consumer accepts it.
- Decouples the bus-width source from the 128-bit core and snapshots the key per block, so key reloads never corrupt a pending block.

Parameters:
- WORD_W, 32, input word width; legal values 8, 16, 32, 64. NUM_WORDS = 128/WORD_W is derived, not overridable.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_wr  in  1  key word write strobe
- key_word  in  WORD_W  key word, MSB-first order
- key_loaded  out  1  high when NUM_WORDS key words have been written since the last reload start
- s_valid  in  1  plaintext word valid
- s_ready  out  1  plaintext word accepted when s_valid && s_ready
- s_word  in  WORD_W  plaintext word, MSB-first order
- s_last  in  1  closes a partial block (used only with the optional feature)
- m_valid  out  1  packed block valid
- m_ready  in  1  consumer accepts block
- m_data  out  128  packed plaintext block, to the core's data_in
- m_key  out  128  key snapshot for this block, to the core's key_in

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_data=0, m_key=0, key_loaded=0; word counters=0; key register=0; state=FILL.
- Reset is asynchronous. Asserting rst_n low mid-block discards the partial data and the key; the key must be reloaded afterwards.
- Word order: the first word lands in bits [127:128-WORD_W], the next word below it, and so on. This applies identically to key and data.
- Key load:
  - Each key_wr shifts key_word into the key register and increments key_cnt.
  - When key_cnt reaches NUM_WORDS, key_loaded=1 and key_cnt wraps to 0.
  - A key_wr while key_loaded=1 starts a new reload: key_loaded drops to 0 in the same cycle the write is registered, and the new key is built from scratch.
- State FILL:
  - s_ready = key_loaded.
  - Each accepted word shifts into the data register and increments data_cnt.
  - Acceptance of word NUM_WORDS-1: m_data is loaded with the full block and m_key with the current key register at that clock edge. m_valid rises the next cycle; go to HOLD; data_cnt=0.
  - If key_loaded drops mid-fill, accepted words are retained and filling resumes once the key completes.
- State HOLD:
  - s_ready=0. m_valid=1.
  - m_data and m_key are stable while m_valid && !m_ready.
  - key_wr is allowed and affects only the key register, never m_key.
  - On m_valid && m_ready: m_valid=0 next cycle; go to FILL.
- Throughput: one block per NUM_WORDS+1 cycles at best. There is no overlap of fill and hold.
- Simultaneous key_wr and s_valid in FILL with key_loaded=1:
  - The key write takes effect; key_loaded falls.
  - The data word IS accepted, because s_ready was high that cycle.
  - If that word completes the block, m_key takes the pre-write key.
- m_ready with m_valid=0 is ignored. s_valid with s_ready=0 is ignored; the word is not consumed.

Optional Feature:
- Macro: AES_PACK_PAD_EN.
- With the macro defined: an accepted word with s_last=1 closes the block early. Remaining low-order words are zero-filled, m_valid rises next cycle, and the block goes to HOLD. s_last on word NUM_WORDS-1 behaves as a normal completion.
- Without the macro: s_last is ignored, and only full blocks of NUM_WORDS words are emitted.

Decomposition:
- Package aes_pkg holds:
  - constants AES_BLOCK_W=128 and AES_KEY_W=128;
  - typedef pack_state_t {FILL, HOLD};
  - the word-count width function.
- One natural sub-module, aes_word_shreg: a WORD_W-in, 128-out MSB-first shift register with counter and full flag. It is instantiated twice, once for key and once for data.

Test Plan:
- Reset, then key 000102030405060708090a0b0c0d0e0f as 4 words, then plaintext 00112233445566778899aabbccddeeff with m_ready=1 -> key_loaded=1 after 4th key_wr; m_valid one cycle after 4th word; m_data and m_key equal the inputs; aes core output 69c4e0d86a7b0430d8cdb78070b4c55a.
- Same block with m_ready=0 for 10 cycles -> m_valid held; m_data/m_key unchanged; s_ready=0 throughout; s_valid words not consumed.
- In HOLD, write new key ffff...ff -> m_key still 0001..0f until handshake; next block carries ffff...ff.
- rst_n pulsed low after 2 of 4 plaintext words -> all outputs 0 immediately; key_loaded=0; s_ready=0 until key reloaded.
- Key reload started after 2 data words -> s_ready drops; on key completion, 2 more words produce a block containing all 4 words and the new key.
- AES_PACK_PAD_EN: words 11111111, 22222222 with s_last on 2nd -> m_data=11111111222222220000000000000000; without macro, no m_valid until 4 words.
